// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Memory words are 32 bits, and PCs advance by one word per fetch.
package fetch_unit_pkg;

   localparam int WORD_LEN = 32;
   localparam logic [WORD_LEN-1:0] START_ADDR_DEFAULT = 32'h0000_0000;
   localparam logic [WORD_LEN-1:0] NOP_INST           = 32'h0000_0013;

   typedef logic [WORD_LEN-1:0] word_t;

   typedef struct packed {
      word_t pc;
      word_t inst;
   } fetch_entry_t;

   // PC arithmetic wraps modulo 2^32
   function automatic word_t next_pc(input word_t pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Output register to decode, backed by a one-entry skid register.
// The skid register catches a response that arrives while decode is stalled.
module fetch_buf
   import fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  fetch_entry_t in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output fetch_entry_t out_data_o
);

   logic         out_valid_q, out_valid_d;
   fetch_entry_t out_data_q, out_data_d;
   logic         skid_valid_q, skid_valid_d;
   fetch_entry_t skid_data_q, skid_data_d;
   logic         out_free;

   assign out_free = !out_valid_q || out_ready_i;

   // The skid entry is older than any incoming response, so it refills the output register first
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = in_valid_i;
            if (in_valid_i) begin
               skid_data_d = in_data_i;
            end
         end else begin
            out_valid_d = in_valid_i;
            if (in_valid_i) begin
               out_data_d = in_data_i;
            end
         end
      end else if (in_valid_i) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign in_ready_o  = !skid_valid_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit. It keeps one memory request in flight and handles redirects.
// Responses are buffered toward decode through fetch_buf.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [WORD_LEN-1:0] START_ADDR = START_ADDR_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   output logic [WORD_LEN-1:0] addr_i,
   input  logic [WORD_LEN-1:0] inst,
   input  logic                redirect_valid,
   input  logic [WORD_LEN-1:0] redirect_pc,
   output logic                id_valid,
   input  logic                id_ready,
   output logic [WORD_LEN-1:0] id_pc,
   output logic [WORD_LEN-1:0] id_inst
);

   word_t        pc_f_q, pc_f_d;
   logic         resp_valid_q, resp_valid_d;
   word_t        resp_pc_q, resp_pc_d;
   logic         issue;
   logic         buf_in_ready;
   fetch_entry_t resp_entry;
   fetch_entry_t out_entry;

   assign addr_i = redirect_valid ? (redirect_pc & ~32'd3) : pc_f_q;

   // Hold off issuing when the response already in flight has nowhere to land except the skid slot
   assign issue = redirect_valid ||
                  (buf_in_ready && !(id_valid && !id_ready && resp_valid_q));

   always_comb begin
      pc_f_d       = pc_f_q;
      resp_pc_d    = resp_pc_q;
      resp_valid_d = issue;
      if (issue) begin
         pc_f_d    = next_pc(addr_i);
         resp_pc_d = addr_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_f_q       <= START_ADDR;
         resp_valid_q <= 1'b0;
         resp_pc_q    <= '0;
      end else begin
         pc_f_q       <= pc_f_d;
         resp_valid_q <= resp_valid_d;
         resp_pc_q    <= resp_pc_d;
      end
   end

   assign resp_entry.pc   = resp_pc_q;
   assign resp_entry.inst = inst;

   fetch_buf u_fetch_buf (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redirect_valid),
      .in_valid_i  (resp_valid_q),
      .in_ready_o  (buf_in_ready),
      .in_data_i   (resp_entry),
      .out_valid_o (id_valid),
      .out_ready_i (id_ready),
      .out_data_o  (out_entry)
   );

   assign id_pc   = out_entry.pc;
   assign id_inst = out_entry.inst;

endmodule
